multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter SUPPORT_JUMP, default 1, meaning opcode 000010 (j) is legal and decoded.
REQ-002 SHALL have parameter SUPPORT_ORI, default 1, meaning opcode 001101 (ori) is legal and decoded.
REQ-003 SHALL have parameter MEM_WAIT, default 1, meaning mem_ready is honoured; when 0, mem_ready is ignored and treated as constant 1.
REQ-004 SHALL have ports, in this order: clk input 1 (sole clock, rising edge); rst input 1 (synchronous, active-high reset); opcode input 6 (instruction-register opcode, stable from DECODE onward); mem_ready input 1 (memory access completes this cycle).
REQ-005 SHALL have outputs: iord 1; mem_write 1; ir_write 1; pc_write 1; branch 1; pc_src 2; alu_src_a 1; alu_src_b 2; reg_dst 1; mem_to_reg 1; reg_write 1; alu_op 2; illegal_op 1; state_o 4 (current state code).

Function
REQ-006 SHALL be a Moore FSM with 4-bit state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11. The only exceptions are the mem_ready qualifiers in REQ-008 and REQ-012, and opcode-dependent outputs in DECODE and IMMEX.
REQ-007 SHALL drive every output not listed for a state to 0.
REQ-008 FETCH outputs: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, with ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-009 DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
- 100011/101011 -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> IMMEX
- 001101 -> IMMEX if SUPPORT_ORI
- 000010 -> JUMP if SUPPORT_JUMP
- otherwise -> FETCH
REQ-010 SHALL assert illegal_op only in a DECODE cycle whose opcode takes the "otherwise" path; opcodes disabled by a parameter count as illegal.
REQ-011 MEMADR outputs: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for 100011, MEMWR for 101011.
REQ-012 MEMRD outputs iord=1; stays until mem_ready, then goes to MEMWB. MEMWR outputs iord=1, mem_write=1; mem_write is held every cycle until mem_ready, then goes to FETCH.
REQ-013 MEMWB outputs reg_dst=0, mem_to_reg=1, reg_write=1; next state FETCH.
REQ-014 EXECUTE outputs alu_src_a=1, alu_src_b=00, alu_op=10; next state ALUWB. ALUWB outputs reg_dst=1, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-015 BRANCH outputs alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01; next state FETCH.
REQ-016 IMMEX outputs alu_src_a=1, alu_src_b=10, alu_op=00 for addi, alu_op=11 for ori; next state IMMWB. IMMWB outputs reg_dst=0, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-017 JUMP outputs pc_src=10, pc_write=1; next state FETCH.
REQ-018 Unreachable codes 12-15 SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-019 Latency with mem_ready=1 SHALL be, in cycles from FETCH entry to the next FETCH entry: R-type 4, lw 5, sw 4, beq 3, addi/ori 4, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.

Reset
REQ-020 rst=1 at a rising edge SHALL force state FETCH from any state, including mid-MEMWR or mid-stall. rst has priority over all transitions.
REQ-021 While in reset, and in the first cycle after it, outputs SHALL be the FETCH values of REQ-008. mem_write SHALL be 0 in the cycle following the reset edge.

Verification
REQ-022 lw, mem_ready=1: reset, opcode=100011 -> state_o sequence 0,1,2,3,4,0; reg_write=mem_to_reg=1 only in state 4.
REQ-023 sw with stall: opcode=101011, mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles, then state 0.
REQ-024 Fetch stall: mem_ready=0 for 2 cycles after reset -> state_o=0 for 3 cycles, ir_write=pc_write=0 for the first 2 and 1 in the third.
REQ-025 Parameter gating: SUPPORT_JUMP=0, opcode=000010 -> illegal_op=1 in the DECODE cycle and next state 0. With SUPPORT_JUMP=1 -> state 11, pc_src=10, pc_write=1.
REQ-026 ori vs addi: opcode=001101 -> alu_op=11 in state 9. opcode=001000 -> alu_op=00 in state 9. Both then reach state 10 with reg_write=1.
REQ-027 Mid-operation reset: rst=1 while state_o=5 and mem_ready=0 -> state_o=0 next cycle, mem_write=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM.
// Moore machine over twelve states. The only input-dependent outputs are the
// mem_ready qualifiers in FETCH (ir_write/pc_write) and the opcode-dependent
// outputs in DECODE (illegal_op) and IMMEX (alu_op).
// While rst is high the outputs already show the FETCH values, so a stalled
// store cannot keep mem_write asserted through a reset.
module multicycle_controller #(
    parameter bit SUPPORT_JUMP = 1'b1,
    parameter bit SUPPORT_ORI  = 1'b1,
    parameter bit MEM_WAIT     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state;
    state_t next_state;

    // With MEM_WAIT off, memory is assumed to always complete in one cycle.
    logic mem_rdy;
    assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

    // Opcode classification; disabled opcodes simply never match.
    logic is_lw, is_sw, is_rtype, is_beq, is_addi, is_ori, is_j, is_legal;
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_ori   = SUPPORT_ORI  && (opcode == OP_ORI);
    assign is_j     = SUPPORT_JUMP && (opcode == OP_J);
    assign is_legal = is_lw | is_sw | is_rtype | is_beq | is_addi | is_ori | is_j;

    assign state_o = state;

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state = S_FETCH;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        illegal_op = 1'b0;

        case (state)
            S_FETCH: begin
                // PC+4 through the ALU; latch IR and PC only once memory answers.
                alu_src_b  = 2'b01;
                ir_write   = mem_rdy;
                pc_write   = mem_rdy;
                next_state = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute the branch target in the ALU while decoding.
                alu_src_b  = 2'b11;
                illegal_op = ~is_legal;
                if (is_lw || is_sw)  next_state = S_MEMADR;
                else if (is_rtype)   next_state = S_EXECUTE;
                else if (is_beq)     next_state = S_BRANCH;
                else if (is_addi)    next_state = S_IMMEX;
                else if (is_ori)     next_state = S_IMMEX;
                else if (is_j)       next_state = S_JUMP;
                else                 next_state = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (is_lw)      next_state = S_MEMRD;
                else if (is_sw) next_state = S_MEMWR;
                else            next_state = S_FETCH;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                // Hold the write request until memory accepts it.
                iord       = 1'b1;
                mem_write  = 1'b1;
                next_state = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                branch     = 1'b1;
                pc_src     = 2'b01;
                next_state = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = is_ori ? 2'b11 : 2'b00;
                next_state = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                // Codes 12-15: all outputs low, recover to FETCH.
                next_state = S_FETCH;
            end
        endcase

        // During reset present the FETCH outputs regardless of the held state.
        if (rst) begin
            iord       = 1'b0;
            mem_write  = 1'b0;
            branch     = 1'b0;
            pc_src     = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_op     = 2'b00;
            illegal_op = 1'b0;
            ir_write   = mem_rdy;
            pc_write   = mem_rdy;
        end
    end

endmodule
